// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 16 sample ticks per bit, mid-bit sampling,
// start-glitch rejection, optional parity, one or two stop bits and break hold-off.
module uart_rx_os #(
  parameter int CLKS_PER_SAMPLE = 651,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 txd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int TW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_SAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;

  state_t               state;
  logic                 txd_m, txd_s;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           s_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_n, ferr_n;
  logic                 tick, mid, last, stop_low_seen;

  assign tick          = (tick_cnt == TICK_LAST);
  assign mid           = (s_cnt == 4'd7);
  assign last          = (s_cnt == 4'd15);
  assign stop_low_seen = ferr_n | ~txd_s;
  assign busy          = (state != S_IDLE);

  // Synchroniser presets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      txd_m <= 1'b1;
      txd_s <= 1'b1;
    end else begin
      txd_m <= txd;
      txd_s <= txd_m;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      tick_cnt    <= '0;
      s_cnt       <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shift       <= '0;
      perr_n      <= 1'b0;
      ferr_n      <= 1'b0;
      data        <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          s_cnt    <= '0;
          bit_cnt  <= '0;
          if (!txd_s) begin
            state    <= S_START;
            perr_n   <= 1'b0;
            ferr_n   <= 1'b0;
            stop_cnt <= 1'b0;
          end
        end
        S_BREAK: begin
          tick_cnt <= '0;
          s_cnt    <= '0;
          if (txd_s) state <= S_IDLE;
        end
        default: begin
          if (!tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end else begin
            tick_cnt <= '0;
            s_cnt    <= s_cnt + 1'b1;
            case (state)
              S_START: begin
                if (mid && txd_s) begin
                  state <= S_IDLE;
                  s_cnt <= '0;
                end else if (last) begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
                end
              end
              S_DATA: begin
                if (mid) shift <= {txd_s, shift[DATA_BITS-1:1]};
                if (last) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) state <= (PARITY != 0) ? S_PAR : S_STOP;
                end
              end
              S_PAR: begin
                // Odd parity wants the XOR over data and parity bit to be 1, even wants 0.
                if (mid) perr_n <= (PARITY == 1) ? ~(^{shift, txd_s}) : (^{shift, txd_s});
                if (last) state <= S_STOP;
              end
              S_STOP: begin
                if (mid) begin
                  if (stop_cnt == STOP_LAST) begin
                    data        <= shift;
                    parity_err  <= perr_n;
                    framing_err <= stop_low_seen;
                    valid       <= 1'b1;
                    state       <= txd_s ? S_IDLE : S_BREAK;
                    s_cnt       <= '0;
                  end else begin
                    ferr_n <= stop_low_seen;
                  end
                end else if (last) begin
                  stop_cnt <= stop_cnt + 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receivers (8N1, 8E1, 7N2) fed directed and random
// frames; a frame-level model predicts every valid word and its status.
module tb_uart_rx_os;

  localparam int C   = 2;
  localparam int BIT = 16 * C;

  logic       clk = 1'b0;
  logic       nreset;
  logic [2:0] txd_v;

  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic valid0, valid1, valid2;
  logic parity_err0, parity_err1, parity_err2;
  logic framing_err0, framing_err1, framing_err2;
  logic busy0, busy1, busy2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [11:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int t2_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.CLKS_PER_SAMPLE(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .nreset(nreset), .txd(txd_v[0]), .data(data0), .valid(valid0),
    .parity_err(parity_err0), .framing_err(framing_err0), .busy(busy0));

  uart_rx_os #(.CLKS_PER_SAMPLE(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .nreset(nreset), .txd(txd_v[1]), .data(data1), .valid(valid1),
    .parity_err(parity_err1), .framing_err(framing_err1), .busy(busy1));

  uart_rx_os #(.CLKS_PER_SAMPLE(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .nreset(nreset), .txd(txd_v[2]), .data(data2), .valid(valid2),
    .parity_err(parity_err2), .framing_err(framing_err2), .busy(busy2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected word = {busy, framing_err, parity_err, data[8:0]}.
  task automatic score(input int d, input logic [8:0] dat, input logic perr,
                       input logic ferr, input logic bsy);
    logic [11:0] e;
    int sz;
    case (d)
      0:       sz = exp_q0.size();
      1:       sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    check($sformatf("d%0d_valid_expected", d), 32'(sz > 0), 1);
    if (sz > 0) begin
      case (d)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      check($sformatf("d%0d_data", d), 32'(dat), 32'(e[8:0]));
      check($sformatf("d%0d_parity_err", d), 32'(perr), 32'(e[9]));
      check($sformatf("d%0d_framing_err", d), 32'(ferr), 32'(e[10]));
      check($sformatf("d%0d_busy_at_valid", d), 32'(bsy), 32'(e[11]));
    end
  endtask

  always @(negedge clk) begin
    if (valid0) score(0, {1'b0, data0}, parity_err0, framing_err0, busy0);
    if (valid1) score(1, {1'b0, data1}, parity_err1, framing_err1, busy1);
    if (valid2) begin
      score(2, {2'b00, data2}, parity_err2, framing_err2, busy2);
      t2_q.push_back(cyc);
    end
  end

  task automatic drive_bits(input int d, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      txd_v[d] = bits[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  // Builds the line waveform for one frame and predicts what the receiver reports.
  task automatic send_frame(input int d, input logic [8:0] dat, input logic pbit,
                            input logic [1:0] stops);
    int db, par, sb, n;
    logic [15:0] bits;
    logic [8:0] dm;
    logic perr, ferr, bsy;
    case (d)
      0:       begin db = 8; par = 0; sb = 1; end
      1:       begin db = 8; par = 2; sb = 1; end
      default: begin db = 7; par = 0; sb = 2; end
    endcase
    bits = '0;
    dm   = '0;
    n    = 1;
    for (int i = 0; i < db; i++) begin
      dm[i]   = dat[i];
      bits[n] = dat[i];
      n++;
    end
    if (par != 0) begin
      bits[n] = pbit;
      n++;
    end
    for (int i = 0; i < sb; i++) begin
      bits[n] = stops[i];
      n++;
    end
    if (par == 1)      perr = ((^dm) ^ pbit) != 1'b1;
    else if (par == 2) perr = ((^dm) ^ pbit) != 1'b0;
    else               perr = 1'b0;
    ferr = !stops[0] || (sb == 2 && !stops[1]);
    bsy  = !stops[sb-1];
    case (d)
      0:       exp_q0.push_back({bsy, ferr, perr, dm});
      1:       exp_q1.push_back({bsy, ferr, perr, dm});
      default: exp_q2.push_back({bsy, ferr, perr, dm});
    endcase
    drive_bits(d, bits, n);
  endtask

  task automatic random_frame(input int d);
    logic [1:0] stops;
    logic final_stop;
    stops[0] = ($urandom_range(0, 3) != 0);
    stops[1] = ($urandom_range(0, 3) != 0);
    final_stop = (d == 2) ? stops[1] : stops[0];
    send_frame(d, 9'($urandom), 1'($urandom), stops);
    if (!final_stop) begin
      repeat ($urandom_range(1, 200)) @(negedge clk);
      txd_v[d] = 1'b1;
    end
    repeat ($urandom_range(2, 40)) @(negedge clk);
  endtask

  initial begin
    txd_v  = 3'b111;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data0", 32'(data0), 0);
    check("rst_valid0", 32'(valid0), 0);
    check("rst_parity_err1", 32'(parity_err1), 0);
    check("rst_framing_err0", 32'(framing_err0), 0);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_data2", 32'(data2), 0);
    nreset = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 basic frame
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    repeat (BIT) @(negedge clk);

    // Start-bit glitch is rejected, then a normal frame follows
    txd_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_high", 32'(busy0), 1);
    txd_v[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_busy_low", 32'(busy0), 0);
    repeat (BIT) @(negedge clk);
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    repeat (BIT) @(negedge clk);

    // 8E1 parity good and bad
    send_frame(1, 9'h007, 1'b1, 2'b11);
    send_frame(1, 9'h007, 1'b0, 2'b11);
    repeat (BIT) @(negedge clk);

    // Back-to-back 7N2 frames, spaced exactly one frame apart
    t2_q.delete();
    send_frame(2, 9'h000, 1'b0, 2'b11);
    send_frame(2, 9'h0FF, 1'b0, 2'b11);
    send_frame(2, 9'h081, 1'b0, 2'b11);
    repeat (2 * BIT) @(negedge clk);
    check("b2b_count", 32'(t2_q.size()), 3);
    if (t2_q.size() == 3) begin
      check("b2b_gap1", 32'(t2_q[1] - t2_q[0]), 32'(10 * BIT));
      check("b2b_gap2", 32'(t2_q[2] - t2_q[1]), 32'(10 * BIT));
    end

    // Random traffic on all three receivers
    for (int k = 0; k < 8; k++) begin
      random_frame(0);
      random_frame(1);
      random_frame(2);
    end
    repeat (BIT) @(negedge clk);

    // Framing error with a held break, then recovery
    send_frame(0, 9'h055, 1'b0, 2'b00);
    repeat (200) @(negedge clk);
    check("break_busy", 32'(busy0), 1);
    txd_v[0] = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(0, 9'h00F, 1'b0, 2'b11);
    repeat (BIT) @(negedge clk);

    // Reset in the middle of bit 4 of 0x99
    drive_bits(0, 16'h0012, 5);
    txd_v[0] = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("midrst_busy_before", 32'(busy0), 1);
    nreset = 1'b0;
    #1;
    check("midrst_data0", 32'(data0), 0);
    check("midrst_busy0", 32'(busy0), 0);
    check("midrst_data1", 32'(data1), 0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    send_frame(0, 9'h042, 1'b0, 2'b11);
    repeat (4 * BIT) @(negedge clk);

    check("q0_drained", 32'(exp_q0.size()), 0);
    check("q1_drained", 32'(exp_q1.size()), 0);
    check("q2_drained", 32'(exp_q2.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised, oversampling UART receiver; successor to the fixed 8-bit divided-clock receiver.
- Runs entirely on the system clock using a sample-tick enable. No derived clocks.
- Configurable data width, parity and stop bits. Reports glitch-rejected, mid-bit-sampled bytes with framing and parity status.
- Sits between the board serial pin and downstream consumers (display, FIFO, command decoder).

Parameters:
- CLKS_PER_SAMPLE, 651: system clocks per oversample tick. The bit period is 16 ticks. 651 gives 9600 baud at 100 MHz; use 2 in simulation.
- DATA_BITS, 8: data bits per frame. Legal range is 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- txd  input  1  asynchronous serial line (host TX); idles high.
- data  output  DATA_BITS  last received word, LSB = first data bit on the line.
- valid  output  1  one-clk pulse when data/status update.
- parity_err  output  1  parity mismatch for the word flagged by valid; held until next valid.
- framing_err  output  1  stop bit sampled low for that word; held until next valid.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (nreset low, asynchronous)
  - data = 0, valid = 0, parity_err = 0, framing_err = 0, busy = 0.
  - state = IDLE; tick counter, sample counter and bit counter = 0.
  - Synchroniser flops preset to 1.
- Input synchroniser: txd passes through 2 flops (txd_s). All decisions use txd_s, so there are 2 clk of input latency.
- Tick generator
  - Counts 0..CLKS_PER_SAMPLE-1 and pulses tick for one clk at the wrap.
  - Free-running while busy; held at 0 in IDLE, restarting on start-edge detect.
  - Each state counts 16 ticks per bit with sample counter s = 0..15. The bit is sampled at s == 7 (mid-bit).
- State machine (advances only on tick, except IDLE)
  - IDLE: txd_s == 0 on any clk -> START, counters cleared.
  - START: at s == 7, if txd_s == 1 -> IDLE (glitch rejected, no valid). Otherwise at s == 15 -> DATA with bit counter = 0.
  - DATA: at s == 7, shift txd_s in LSB-first. At s == 15, bit counter increments; after DATA_BITS bits -> PARITY if PARITY != 0, else STOP.
  - PARITY: at s == 7, compute parity_err_next. Odd requires XOR(data, bit) == 1; even requires == 0. At s == 15 -> STOP.
  - STOP: at s == 7 of each stop bit, a low sample sets framing_err_next.
    - With STOP_BITS == 2, the first stop bit runs to s == 15 and the second is then sampled.
    - At s == 7 of the final stop bit: load data, parity_err and framing_err; pulse valid for one clk.
    - If the stop sample was high -> IDLE immediately (mid-stop), allowing back-to-back frames. If low -> BREAK.
  - BREAK: wait until txd_s == 1 with no tick counting, then -> IDLE. No further valid is produced during a held-low line.
- Latency: valid asserts (1 + DATA_BITS + P + STOP_BITS - 0.5) bit periods + 2..3 clk after the txd falling edge, where P = 1 if parity is enabled.
- Width rules
  - Shift register is DATA_BITS wide.
  - Bit counter is clog2(DATA_BITS+1) wide; tick counter is clog2(CLKS_PER_SAMPLE) wide.
  - Unused parity logic is optimised away when PARITY == 0, and parity_err stays 0.
- Reset mid-frame: immediate abort to IDLE with all outputs cleared. The partial word is discarded; the next falling edge starts a new frame.
- Status flags update only together with valid; they are never cleared by reading.

Test Plan:
- Config: CLKS_PER_SAMPLE=2, 8N1, bit = 32 clk. Send 0xA5 (line order 1,0,1,0,0,1,0,1) -> exactly one valid pulse, data = 0xA5, parity_err = 0, framing_err = 0, busy falls the same cycle.
- Glitch: txd low for 10 clk, then high -> no valid; busy returns to 0 at mid-start; a following 0x3C frame is received correctly.
- Config 8E1: send 0x07 with parity bit 1 -> data = 0x07, parity_err = 0. Send 0x07 with parity bit 0 -> parity_err = 1.
- Framing/break: send 0x55 with stop bit low, hold line low 200 clk -> single valid, data = 0x55, framing_err = 1; no further valid until after the line returns high and the next frame 0x0F gives framing_err = 0.
- Back-to-back: 0x00, 0xFF, 0x81 with no idle gap, 2 stop bits, DATA_BITS = 7 -> three valids with data 0x00, 0x7F, 0x01, spaced 10 bit periods.
- Reset mid-DATA: assert nreset low for 3 clk at bit 4 of 0x99 -> outputs 0 immediately, no valid for that frame; next frame 0x42 -> data = 0x42.
